// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data-port memory controller. Request strobes are queued in a
// small FIFO, each access spends WAIT_CYCLES wait states before committing to the
// word-addressed RAM, and DataDone pulses once per accepted request.
// Optional feature: define DMEM_MMIO_EN to map IO_ADDR onto the IoOut register.
module data_mem_ctrl #(
    parameter int unsigned          WORD_SIZE   = 16,
    parameter int unsigned          DEPTH       = 256,
    parameter int unsigned          WAIT_CYCLES = 2,
    parameter int unsigned          FIFO_DEPTH  = 2,
    parameter logic [WORD_SIZE-1:0] IO_ADDR     = 16'hF000
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 ReadData,
    input  logic                 WriteData,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataDone,
    output logic                 Busy,
    output logic                 AddrErr,
    output logic                 Overflow,
    output logic [WORD_SIZE-1:0] IoOut
);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FILL_W = PTR_W + 1;
    localparam int unsigned CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DMEM_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    typedef struct packed {
        logic                 we;
        logic [WORD_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 load_c, commit_c;
    logic                 req_c, full_c, push_c;
    req_t                 push_req_c;
    req_t                 fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [FILL_W-1:0]    fill_q;
    req_t                 work_q;
    logic                 in_range_c, is_io_c;
    logic [WORD_SIZE-1:0] io_val;
    logic [WORD_SIZE-1:0] mem [DEPTH];
    logic [WORD_SIZE-1:0] data_in_q;
    logic                 done_q, addr_err_q, ovf_q;

    // Request capture; a write strobe wins when both strobes are set
    assign req_c      = ReadData | WriteData;
    assign push_req_c = '{we: WriteData, addr: DataAddr, wdata: DataOut};
    assign full_c     = (fill_q == FILL_W'(FIFO_DEPTH));
    assign push_c     = req_c && (!full_c || load_c);
    assign Busy       = full_c;

    // Address decode of the access being committed (full-width compare, no wrap)
    assign in_range_c = (work_q.addr < WORD_SIZE'(DEPTH));
    assign is_io_c    = MMIO_EN && (work_q.addr == IO_ADDR);

    // FSM state and wait counter register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: pop into working regs, count wait states, commit on the way into DONE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_c   = 1'b0;
        commit_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fill_q != '0) begin
                    load_c  = 1'b1;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    commit_c = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (fill_q != '0) begin
                    load_c  = 1'b1;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO pointers and occupancy
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (load_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            fill_q <= fill_q + FILL_W'(push_c) - FILL_W'(load_c);
        end
    end

    // FIFO payload storage and working registers (data only, no reset needed)
    always_ff @(posedge Clock) begin
        if (push_c) fifo_q[wr_ptr_q] <= push_req_c;
        if (load_c) work_q <= fifo_q[rd_ptr_q];
    end

    // Backing RAM, written only when an in-range write commits
    always_ff @(posedge Clock) begin
        if (commit_c && work_q.we && in_range_c) mem[work_q.addr[RAM_AW-1:0]] <= work_q.wdata;
    end

`ifdef DMEM_MMIO_EN
    logic [WORD_SIZE-1:0] io_q;

    // MMIO output register, loaded by committed writes to IO_ADDR
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            io_q <= '0;
        end else if (commit_c && work_q.we && is_io_c) begin
            io_q <= work_q.wdata;
        end
    end

    assign io_val = io_q;
`else
    assign io_val = '0;
`endif

    // Completion pulse, read data and sticky error flags
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            done_q     <= 1'b0;
            data_in_q  <= '0;
            addr_err_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            done_q <= commit_c;
            if (commit_c && !work_q.we) begin
                if (in_range_c)   data_in_q <= mem[work_q.addr[RAM_AW-1:0]];
                else if (is_io_c) data_in_q <= io_val;
                else              data_in_q <= '0;
            end
            if (commit_c && !in_range_c && !is_io_c) addr_err_q <= 1'b1;
            if (req_c && full_c && !load_c)           ovf_q      <= 1'b1;
        end
    end

    assign DataIn   = data_in_q;
    assign DataDone = done_q;
    assign AddrErr  = addr_err_q;
    assign Overflow = ovf_q;
    assign IoOut    = io_val;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed scenarios plus randomized traffic against a
// transaction-level schedule model of data_mem_ctrl.
`timescale 1ns/1ps
module tb_data_mem_ctrl;
    localparam int WC = 2;
    localparam int FD = 2;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic [15:0] DataAddr = 16'h0;
    logic [15:0] DataOut = 16'h0;
    logic        ReadData = 1'b0;
    logic        WriteData = 1'b0;
    logic [15:0] DataIn;
    logic        DataDone, Busy, AddrErr, Overflow;
    logic [15:0] IoOut;

    always #5 Clock = ~Clock;

    data_mem_ctrl #(
        .WORD_SIZE(16), .DEPTH(256), .WAIT_CYCLES(WC), .FIFO_DEPTH(FD), .IO_ADDR(16'hF000)
    ) dut (
        .Clock(Clock), .Resetn(Resetn), .DataAddr(DataAddr), .DataOut(DataOut),
        .ReadData(ReadData), .WriteData(WriteData), .DataIn(DataIn), .DataDone(DataDone),
        .Busy(Busy), .AddrErr(AddrErr), .Overflow(Overflow), .IoOut(IoOut)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: each accepted request gets a pop edge s and a commit edge d.
    typedef struct {
        int          p;
        int          s;
        int          d;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mreq_t;

    mreq_t       q[$];
    int          cyc = 0;
    int          last_d = -100;
    logic [15:0] ref_mem [256];
    bit          ref_known [256];
    logic [15:0] exp_din = 16'h0;
    logic [15:0] exp_io = 16'h0;
    bit          exp_din_ok = 1'b1;
    bit          exp_done = 1'b0, exp_busy = 1'b0, exp_aerr = 1'b0, exp_ovf = 1'b0;

    function automatic void commit(input mreq_t r);
        bit in_rng;
        bit is_io;
        in_rng = (r.addr < 16'd256);
        is_io  = 1'b0;
`ifdef DMEM_MMIO_EN
        is_io = (r.addr == 16'hF000);
`endif
        if (in_rng) begin
            if (r.we) begin
                ref_mem[r.addr[7:0]]   = r.wdata;
                ref_known[r.addr[7:0]] = 1'b1;
            end else begin
                exp_din    = ref_mem[r.addr[7:0]];
                exp_din_ok = ref_known[r.addr[7:0]];
            end
        end else if (is_io) begin
            if (r.we) exp_io = r.wdata;
            else begin
                exp_din    = exp_io;
                exp_din_ok = 1'b1;
            end
        end else begin
            exp_aerr = 1'b1;
            if (!r.we) begin
                exp_din    = 16'h0;
                exp_din_ok = 1'b1;
            end
        end
    endfunction

    task automatic model_edge(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
        int    occ;
        bit    pop;
        mreq_t r;
        exp_done = 1'b0;
        while (q.size() > 0 && q[0].d == cyc) begin
            r = q.pop_front();
            commit(r);
            exp_done = 1'b1;
        end
        occ = 0;
        pop = 1'b0;
        foreach (q[i]) begin
            if (q[i].p < cyc && q[i].s >= cyc) occ++;
            if (q[i].s == cyc) pop = 1'b1;
        end
        if (rd || wr) begin
            if (occ < FD || pop) begin
                r.p     = cyc;
                r.s     = (cyc + 1 > last_d + 1) ? cyc + 1 : last_d + 1;
                r.d     = r.s + 1 + WC;
                r.we    = wr;
                r.addr  = a;
                r.wdata = d;
                last_d  = r.d;
                q.push_back(r);
            end else begin
                exp_ovf = 1'b1;
            end
        end
        occ = 0;
        foreach (q[i]) if (q[i].p <= cyc && q[i].s > cyc) occ++;
        exp_busy = (occ == FD);
    endtask

    // One clock: drive strobes, advance model at the edge, return at the falling edge
    task automatic tick(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
        ReadData  = rd;
        WriteData = wr;
        DataAddr  = a;
        DataOut   = d;
        @(posedge Clock);
        cyc++;
        model_edge(rd, wr, a, d);
        @(negedge Clock);
        ReadData  = 1'b0;
        WriteData = 1'b0;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic do_reset();
        ReadData  = 1'b0;
        WriteData = 1'b0;
        Resetn    = 1'b0;
        q.delete();
        last_d     = -100;
        exp_din    = 16'h0;
        exp_din_ok = 1'b1;
        exp_io     = 16'h0;
        exp_done   = 1'b0;
        exp_busy   = 1'b0;
        exp_aerr   = 1'b0;
        exp_ovf    = 1'b0;
        repeat (3) begin
            @(posedge Clock);
            cyc++;
        end
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            idle();
            n_checks++; if (DataDone !== 1'b0) $display("FAIL reset_done cyc=%0d got=%b exp=0", i, DataDone); else n_pass++;
        end
        n_checks++; if (Busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", Busy); else n_pass++;
        n_checks++; if (AddrErr !== 1'b0) $display("FAIL reset_addrerr got=%b exp=0", AddrErr); else n_pass++;
        n_checks++; if (Overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", Overflow); else n_pass++;
        n_checks++; if (DataIn !== 16'h0) $display("FAIL reset_datain got=%h exp=0000", DataIn); else n_pass++;
        n_checks++; if (IoOut !== 16'h0) $display("FAIL reset_ioout got=%h exp=0000", IoOut); else n_pass++;
    endtask

    task automatic test_write_read();
        int          n0, p1, p2;
        logic [15:0] d2;
        do_reset();
        tick(1'b0, 1'b1, 16'd5, 16'hBEEF);
        n0 = cyc;
        tick(1'b1, 1'b0, 16'd5, 16'h0);
        p1 = -1;
        p2 = -1;
        d2 = 16'hxxxx;
        for (int i = 0; i < 16; i++) begin
            if (DataDone === 1'b1) begin
                if (p1 < 0) p1 = cyc;
                else if (p2 < 0) begin
                    p2 = cyc;
                    d2 = DataIn;
                end
            end
            idle();
        end
        n_checks++; if (p1 != n0 + 4) $display("FAIL wr_first_pulse got=%0d exp=%0d", p1 - n0, 4); else n_pass++;
        n_checks++; if (p2 != n0 + 8) $display("FAIL rd_second_pulse got=%0d exp=%0d", p2 - n0, 8); else n_pass++;
        n_checks++; if (d2 !== 16'hBEEF) $display("FAIL rd_data got=%h exp=beef", d2); else n_pass++;
    endtask

    task automatic test_overflow();
        int pulses;
        do_reset();
        pulses = 0;
        tick(1'b1, 1'b0, 16'd1, 16'h0);
        idle();
        tick(1'b0, 1'b1, 16'd2, 16'h2222);
        tick(1'b1, 1'b0, 16'd2, 16'h0);
        n_checks++; if (Busy !== 1'b1) $display("FAIL ovf_busy got=%b exp=1", Busy); else n_pass++;
        n_checks++; if (Overflow !== 1'b0) $display("FAIL ovf_early got=%b exp=0", Overflow); else n_pass++;
        tick(1'b1, 1'b0, 16'd3, 16'h0);
        if (DataDone === 1'b1) pulses++;
        n_checks++; if (Overflow !== 1'b1) $display("FAIL ovf_set got=%b exp=1", Overflow); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            idle();
            if (DataDone === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 3) $display("FAIL ovf_pulses got=%0d exp=3", pulses); else n_pass++;
        n_checks++; if (Overflow !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", Overflow); else n_pass++;
        n_checks++; if (DataIn !== 16'h2222) $display("FAIL ovf_datain got=%h exp=2222", DataIn); else n_pass++;
    endtask

    task automatic test_addr_err();
        do_reset();
        tick(1'b0, 1'b1, 16'd3, 16'h5A5A);
        tick(1'b1, 1'b0, 16'd3, 16'h0);
        repeat (12) idle();
        n_checks++; if (DataIn !== 16'h5A5A) $display("FAIL aerr_pre_datain got=%h exp=5a5a", DataIn); else n_pass++;
        n_checks++; if (AddrErr !== 1'b0) $display("FAIL aerr_pre got=%b exp=0", AddrErr); else n_pass++;
        tick(1'b1, 1'b0, 16'h0100, 16'h0);
        for (int i = 0; i < 20 && DataDone !== 1'b1; i++) idle();
        n_checks++; if (DataDone !== 1'b1) $display("FAIL aerr_done got=%b exp=1", DataDone); else n_pass++;
        n_checks++; if (DataIn !== 16'h0) $display("FAIL aerr_datain got=%h exp=0000", DataIn); else n_pass++;
        n_checks++; if (AddrErr !== 1'b1) $display("FAIL aerr_set got=%b exp=1", AddrErr); else n_pass++;
        repeat (5) idle();
        n_checks++; if (AddrErr !== 1'b1) $display("FAIL aerr_sticky got=%b exp=1", AddrErr); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        int stray;
        do_reset();
        tick(1'b0, 1'b1, 16'd7, 16'h1111);
        repeat (6) idle();
        tick(1'b0, 1'b1, 16'd7, 16'h1234);
        idle();
        idle();
        do_reset();
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            idle();
            if (DataDone !== 1'b0) stray++;
        end
        n_checks++; if (stray != 0) $display("FAIL rst_stray_done got=%0d exp=0", stray); else n_pass++;
        tick(1'b1, 1'b0, 16'd7, 16'h0);
        for (int i = 0; i < 20 && DataDone !== 1'b1; i++) idle();
        n_checks++; if (DataDone !== 1'b1) $display("FAIL rst_read_done got=%b exp=1", DataDone); else n_pass++;
        n_checks++; if (DataIn !== 16'h1111) $display("FAIL rst_read_data got=%h exp=1111", DataIn); else n_pass++;
    endtask

    task automatic test_mmio();
        do_reset();
        tick(1'b0, 1'b1, 16'hF000, 16'h00A5);
        for (int i = 0; i < 20 && DataDone !== 1'b1; i++) idle();
        n_checks++; if (DataDone !== 1'b1) $display("FAIL mmio_done got=%b exp=1", DataDone); else n_pass++;
        idle();
`ifdef DMEM_MMIO_EN
        n_checks++; if (IoOut !== 16'h00A5) $display("FAIL mmio_ioout got=%h exp=00a5", IoOut); else n_pass++;
        n_checks++; if (AddrErr !== 1'b0) $display("FAIL mmio_addrerr got=%b exp=0", AddrErr); else n_pass++;
        tick(1'b1, 1'b0, 16'hF000, 16'h0);
        for (int i = 0; i < 20 && DataDone !== 1'b1; i++) idle();
        n_checks++; if (DataIn !== 16'h00A5) $display("FAIL mmio_readback got=%h exp=00a5", DataIn); else n_pass++;
`else
        n_checks++; if (IoOut !== 16'h0) $display("FAIL mmio_ioout got=%h exp=0000", IoOut); else n_pass++;
        n_checks++; if (AddrErr !== 1'b1) $display("FAIL mmio_addrerr got=%b exp=1", AddrErr); else n_pass++;
`endif
    endtask

    task automatic test_random();
        int          r, k;
        bit          rd, wr;
        logic [15:0] a, d;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b1, 16'(i), 16'($urandom));
            repeat (3) idle();
        end
        for (int i = 0; i < 800; i++) begin
            if (i == 300 || i == 550) do_reset();
            r  = int'($urandom_range(0, 99));
            rd = (r < 25) || (r >= 45 && r < 50);
            wr = (r >= 25 && r < 50);
            k  = int'($urandom_range(0, 19));
            if (k < 16)      a = 16'(k % 8);
            else if (k < 18) a = 16'h0100 + 16'($urandom_range(0, 255));
            else             a = 16'hF000;
            d = 16'($urandom);
            tick(rd, wr, a, d);
            n_checks++; if (DataDone !== exp_done) $display("FAIL rnd_done i=%0d got=%b exp=%b", i, DataDone, exp_done); else n_pass++;
            n_checks++; if (Busy !== exp_busy) $display("FAIL rnd_busy i=%0d got=%b exp=%b", i, Busy, exp_busy); else n_pass++;
            n_checks++; if (Overflow !== exp_ovf) $display("FAIL rnd_overflow i=%0d got=%b exp=%b", i, Overflow, exp_ovf); else n_pass++;
            n_checks++; if (AddrErr !== exp_aerr) $display("FAIL rnd_addrerr i=%0d got=%b exp=%b", i, AddrErr, exp_aerr); else n_pass++;
            n_checks++; if (IoOut !== exp_io) $display("FAIL rnd_ioout i=%0d got=%h exp=%h", i, IoOut, exp_io); else n_pass++;
            if (exp_din_ok) begin
                n_checks++; if (DataIn !== exp_din) $display("FAIL rnd_datain i=%0d got=%h exp=%h", i, DataIn, exp_din); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_overflow();
        test_addr_err();
        test_reset_mid_wait();
        test_mmio();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound so the run always ends on its own
    initial begin
        #1000000;
        $display("FAIL timeout reached before summary, checks=%0d passed=%0d", n_checks, n_pass);
        $fatal(1, "timeout");
    end

endmodule
